// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I multi-cycle control unit.
// Holds opcode constants, ALU funct_select codes, the controller state
// enum, the datapath mux encodings and a legality check for instruction
// words. No ports.
package rv32i_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // ALU funct_select: bit4 = subtract/carry-in, [3:0] = operation
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b10000;
    localparam logic [4:0] ALU_XOR  = 5'b00001;
    localparam logic [4:0] ALU_OR   = 5'b00010;
    localparam logic [4:0] ALU_AND  = 5'b00011;
    localparam logic [4:0] ALU_SLTU = 5'b00100;
    localparam logic [4:0] ALU_SLT  = 5'b00101;

    // Datapath mux encodings
    localparam logic [1:0] SRC1_RS1  = 2'd0;
    localparam logic [1:0] SRC1_PC   = 2'd1;
    localparam logic [1:0] SRC1_ZERO = 2'd2;
    localparam logic [1:0] SRC2_RS2  = 2'd0;
    localparam logic [1:0] SRC2_IMM  = 2'd1;
    localparam logic [1:0] SRC2_FOUR = 2'd2;
    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_MEM    = 2'd1;
    localparam logic [1:0] WB_PC4    = 2'd2;
    localparam logic [1:0] WB_IMM    = 2'd3;
    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JALR   = 2'd2;
    localparam logic [1:0] SH_SLL    = 2'd0;
    localparam logic [1:0] SH_SRL    = 2'd1;
    localparam logic [1:0] SH_SRA    = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    // True for every RV32I word this controller executes. SYSTEM
    // (ECALL/EBREAK/CSR) is deliberately rejected so it lands in TRAP.
    function automatic logic instr_legal(input logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ok;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL: ok = 1'b1;
            OP_JALR:   ok = (f3 == 3'b000);
            OP_BRANCH: ok = (f3 != 3'b010) && (f3 != 3'b011);
            OP_LOAD:   ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            OP_STORE:  ok = (f3 <= 3'b010);
            OP_IMM: begin
                if (f3 == 3'b001)
                    ok = (f7 == 7'h00);
                else if (f3 == 3'b101)
                    ok = (f7 == 7'h00) || (f7 == 7'h20);
                else
                    ok = 1'b1;
            end
            OP_REG:    ok = (f7 == 7'h00) ||
                            ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
            OP_FENCE:  ok = (f3 == 3'b000);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// Immediate extraction for the RV32I formats (I, S, B, U, J).
// Ports:
//   instr  in  32  latched instruction word
//   imm    out 32  sign-extended immediate (0 for R-type / unknown opcodes)
module rv32i_imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    logic [6:0] opcode;
    assign opcode = instr[6:0];

    always_comb begin
        imm = '0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM:
                imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {instr[31:12], 12'b0};
            OP_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle control unit for an RV32I core.
// Sequences FETCH -> DECODE -> EXEC -> [MEM] -> [WB] and drives the
// datapath muxes, ALU code, shifter select and memory requests.
//
// Handshakes: imem_req/dmem_req are held high, with their qualifiers
// (dmem_we/size/unsigned) stable, until the matching *_ready is seen high
// at a rising edge; that edge completes the transfer. A ready without a
// request is ignored.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   imem_req/ready/rdata         instruction fetch handshake
//   dmem_req/we/size/unsigned/ready  data access handshake
//   alu_funct_select, alu_src1_sel, alu_src2_sel, alu_zero, alu_lt  ALU control/flags
//   shift_en, shift_type         shifter write-back select
//   rs1_addr, rs2_addr, rd_addr, imm  decoded fields of the latched word
//   reg_we, wb_sel               register write-back control
//   pc_we, pc_sel, pc_init       PC update control and reset vector
//   illegal_instr                sticky trap indication
//   instr_retired                one pulse per completed instruction
//   dbg_state                    current controller state
module rv32i_mc_ctrl
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [1:0]  dmem_size,
    output logic        dmem_unsigned,
    input  logic        dmem_ready,
    output logic [4:0]  alu_funct_select,
    output logic [1:0]  alu_src1_sel,
    output logic [1:0]  alu_src2_sel,
    input  logic        alu_zero,
    input  logic        alu_lt,
    output logic        shift_en,
    output logic [1:0]  shift_type,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic [31:0] imm,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [31:0] pc_init,
    output logic        illegal_instr,
    output logic        instr_retired,
    output state_t      dbg_state
);

    state_t      state, next_state;
    logic [31:0] ir;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    assign rs1_addr  = ir[19:15];
    assign rs2_addr  = ir[24:20];
    assign rd_addr   = ir[11:7];
    assign pc_init   = RESET_PC;
    assign dbg_state = state;

    // TRAP is only left through reset, so the state itself is the sticky flag.
    assign illegal_instr = (state == S_TRAP) && !rst;

    rv32i_imm_gen u_imm_gen (
        .instr (ir),
        .imm   (imm)
    );

    // Datapath control decoded purely from the instruction register. It is
    // constant for the whole instruction, so driving it in EXEC, MEM and WB
    // keeps the ALU address/result stable until write-back.
    logic [4:0] dec_funct;
    logic [1:0] dec_src1, dec_src2;
    logic       dec_shift_en;
    logic [1:0] dec_shift_type;
    logic [1:0] dec_wb_sel, dec_pc_sel;
    logic       br_taken;

    always_comb begin
        dec_funct      = ALU_ADD;
        dec_src1       = SRC1_RS1;
        dec_src2       = SRC2_RS2;
        dec_shift_en   = 1'b0;
        dec_shift_type = SH_SLL;
        dec_wb_sel     = WB_ALU;
        dec_pc_sel     = PC_PLUS4;
        case (opcode)
            OP_REG, OP_IMM: begin
                if (opcode == OP_IMM)
                    dec_src2 = SRC2_IMM;
                case (funct3)
                    3'b000: dec_funct = (opcode == OP_REG && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001: begin
                        dec_shift_en   = 1'b1;
                        dec_shift_type = SH_SLL;
                    end
                    3'b010: dec_funct = ALU_SLT;
                    3'b011: dec_funct = ALU_SLTU;
                    3'b100: dec_funct = ALU_XOR;
                    3'b101: begin
                        dec_shift_en   = 1'b1;
                        dec_shift_type = funct7[5] ? SH_SRA : SH_SRL;
                    end
                    3'b110: dec_funct = ALU_OR;
                    3'b111: dec_funct = ALU_AND;
                endcase
            end
            OP_LOAD: begin
                dec_src2   = SRC2_IMM;
                dec_wb_sel = WB_MEM;
            end
            OP_STORE:
                dec_src2 = SRC2_IMM;
            OP_BRANCH:
                dec_funct = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
            OP_JAL: begin
                dec_wb_sel = WB_PC4;
                dec_pc_sel = PC_BRANCH;
            end
            OP_JALR: begin
                dec_src2   = SRC2_IMM;
                dec_wb_sel = WB_PC4;
                dec_pc_sel = PC_JALR;
            end
            OP_LUI:
                dec_wb_sel = WB_IMM;
            OP_AUIPC: begin
                dec_src1 = SRC1_PC;
                dec_src2 = SRC2_IMM;
            end
            default: ;
        endcase
    end

    // funct3[2] picks the flag (zero for EQ/NE, lt for the compares);
    // funct3[0] inverts the sense for BNE/BGE/BGEU.
    assign br_taken = (funct3[2] ? alu_lt : alu_zero) ^ funct3[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == S_FETCH && imem_ready)
                ir <= imem_rdata;
        end
    end

    always_comb begin
        next_state       = state;
        imem_req         = 1'b0;
        dmem_req         = 1'b0;
        dmem_we          = 1'b0;
        dmem_size        = 2'b00;
        dmem_unsigned    = 1'b0;
        alu_funct_select = ALU_ADD;
        alu_src1_sel     = SRC1_RS1;
        alu_src2_sel     = SRC2_RS2;
        shift_en         = 1'b0;
        shift_type       = SH_SLL;
        reg_we           = 1'b0;
        wb_sel           = WB_ALU;
        pc_we            = 1'b0;
        pc_sel           = PC_PLUS4;
        instr_retired    = 1'b0;

        // While rst is high every strobe stays low, even before the state
        // register has been forced back to FETCH.
        if (!rst) begin
            if (state inside {S_EXEC, S_MEM, S_WB}) begin
                alu_funct_select = dec_funct;
                alu_src1_sel     = dec_src1;
                alu_src2_sel     = dec_src2;
                shift_en         = dec_shift_en;
                shift_type       = dec_shift_type;
            end

            case (state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready)
                        next_state = S_DECODE;
                end
                S_DECODE: begin
                    if (!instr_legal(ir)) begin
                        next_state = S_TRAP;
                    end else if (opcode == OP_FENCE) begin
                        pc_we         = 1'b1;
                        pc_sel        = PC_PLUS4;
                        instr_retired = 1'b1;
                        next_state    = S_FETCH;
                    end else begin
                        next_state = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (opcode == OP_BRANCH) begin
                        pc_we         = 1'b1;
                        pc_sel        = br_taken ? PC_BRANCH : PC_PLUS4;
                        instr_retired = 1'b1;
                        next_state    = S_FETCH;
                    end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                        next_state = S_MEM;
                    end else begin
                        next_state = S_WB;
                    end
                end
                S_MEM: begin
                    dmem_req      = 1'b1;
                    dmem_we       = (opcode == OP_STORE);
                    dmem_size     = funct3[1:0];
                    dmem_unsigned = funct3[2];
                    if (dmem_ready) begin
                        if (opcode == OP_STORE) begin
                            pc_we         = 1'b1;
                            pc_sel        = PC_PLUS4;
                            instr_retired = 1'b1;
                            next_state    = S_FETCH;
                        end else begin
                            next_state = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_we        = (rd_addr != 5'd0);
                    wb_sel        = dec_wb_sel;
                    pc_we         = 1'b1;
                    pc_sel        = dec_pc_sel;
                    instr_retired = 1'b1;
                    next_state    = S_FETCH;
                end
                S_TRAP:
                    next_state = S_TRAP;
                default:
                    next_state = S_FETCH;
            endcase
        end
    end

endmodule

// File: doc/rv32i_mc_ctrl.md
Name: rv32i_mc_ctrl

Overview:
- Multi-cycle control unit for the RV32I core.
- Fetches and decodes each instruction, then sequences the datapath through execute, memory and write-back.
- Drives the ALU's 5-bit funct_select: bit4 = subtract/carry-in; [3:0]: 0 ADD, 1 XOR, 2 OR, 3 AND, 4 SLTU, 5 SLT.
- Branches are resolved from ALU flags (Z, result bit 0). Shifts go to an external shifter.

Parameters:
RESET_PC, 32'h0000_0000, value driven on pc_init while rst is high; datapath loads PC from it.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  instruction fetch request
imem_ready  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  32  instruction word
dmem_req  out  1  data access request
dmem_we  out  1  1 = store
dmem_size  out  2  0 byte, 1 half, 2 word
dmem_unsigned  out  1  LBU/LHU
dmem_ready  in  1  data access complete
alu_funct_select  out  5  ALU operation code
alu_src1_sel  out  2  0 rs1, 1 pc, 2 zero
alu_src2_sel  out  2  0 rs2, 1 imm, 2 const 4
alu_zero  in  1  ALU Z flag
alu_lt  in  1  ALU result bit 0 (SLT/SLTU outcome)
shift_en  out  1  write-back source is the shifter
shift_type  out  2  0 SLL, 1 SRL, 2 SRA
rs1_addr, rs2_addr, rd_addr  out  5 each  register file addresses
imm  out  32  sign-extended immediate
reg_we  out  1  register write strobe
wb_sel  out  2  0 alu, 1 mem, 2 pc+4, 3 imm (LUI)
pc_we  out  1  PC update strobe
pc_sel  out  2  0 pc+4, 1 pc+imm, 2 alu_out & ~1
pc_init  out  32  RESET_PC
illegal_instr  out  1  sticky trap flag
instr_retired  out  1  one-cycle pulse per completed instruction

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset:
  - On rst high at a clock edge: state goes to FETCH.
  - All strobes/requests go to 0, illegal_instr to 0, instruction register to 0.
  - Reset mid-handshake abandons the access; req is low on the next cycle.
- FETCH:
  - imem_req = 1, held until imem_ready.
  - On imem_ready: latch imem_rdata, go to DECODE.
  - imem_ready without req is ignored.
- DECODE (1 cycle):
  - Outputs rs/rd/imm from the latched word.
  - Illegal opcode or funct3/funct7 goes to TRAP.
  - ECALL/EBREAK go to TRAP.
  - FENCE is a NOP: pc_we with pc_sel 0, instr_retired, go to FETCH.
- EXEC:
  - R/I ALU ops:
    - funct_select per op: SUB = 5'b10000, ADD/ADDI = 00000, SLTI = 00101, etc.
    - Go to WB.
    - Shifts assert shift_en and shift_type instead of an ALU code.
  - LOAD/STORE: ADD rs1 + imm, go to MEM.
  - Branch:
    - BEQ/BNE use SUB and alu_zero.
    - BLT/BGE use 00101 and alu_lt.
    - BLTU/BGEU use 00100 and alu_lt.
    - Same cycle: pc_we = 1; pc_sel = 1 if taken else 0; instr_retired; go to FETCH.
  - JAL: go to WB.
  - JALR: ADD rs1 + imm, go to WB.
  - LUI/AUIPC: go to WB.
- MEM:
  - dmem_req held, with dmem_we/size/unsigned stable until dmem_ready.
  - Load goes to WB.
  - Store: pc_we, instr_retired, go to FETCH.
- WB (1 cycle):
  - reg_we = 1 unless rd = 0.
  - pc_we = 1: JAL pc_sel 1, JALR pc_sel 2, else pc_sel 0.
  - wb_sel: 2 for JAL/JALR, 1 for loads, 3 for LUI, 0 otherwise.
  - instr_retired, go to FETCH.
- TRAP:
  - illegal_instr = 1; all strobes 0.
  - Stays in TRAP until rst.
- Latency with zero-wait memory: ALU op 4, load 5, store 4, branch 3, JAL/JALR 4 cycles.
- ALU outputs are held at their EXEC values through MEM/WB so the address and result stay stable.

Decomposition:
- Package rv32i_pkg holds:
  - opcode constants
  - ALU funct_select codes
  - state enum
  - alu_src/wb_sel/pc_sel encodings
- Sub-module rv32i_imm_gen: combinational I/S/B/U/J immediate extraction.

Test Plan:
- rst held 3 cycles, then released -> state FETCH, imem_req = 1 on first cycle, pc_init = RESET_PC, all other outputs 0.
- SUB x3,x1,x2 (32'h402081B3), imem_ready after 2 wait cycles:
  - EXEC funct_select = 5'b10000.
  - WB: reg_we = 1, rd_addr = 3, wb_sel = 0.
  - instr_retired once.
- BNE with alu_zero = 0, then alu_zero = 1 -> pc_sel = 1 vs 0, pc_we high exactly 1 cycle, no reg_we.
- LW x5,8(x1) (32'h0080A283) with dmem_ready delayed 3 cycles:
  - dmem_req stable 4 cycles, size = 2, we = 0.
  - Then WB with wb_sel = 1, rd_addr = 5.
- rst asserted mid-MEM (dmem_req = 1) -> next cycle dmem_req = 0, state FETCH, no reg_we.
- Opcode 7'b1111111 -> illegal_instr = 1, stays 1 and imem_req stays 0 for 10+ cycles until rst.
